// File: rtl/ram_ctrl_if.sv
// Request/response bundle between the CPU memory-access stage and ram_ctrl.
interface ram_ctrl_if #(
  parameter int datalines = 16,
  parameter int adlines   = 8
);
  logic [adlines-1:0]   address;
  logic [datalines-1:0] datain;
  logic                 read;
  logic                 write;
  logic                 clear;
  logic [datalines-1:0] dataout;
  logic                 busy;
  logic                 ack;
  logic                 err;

  modport master (
    output address, datain, read, write, clear,
    input  dataout, busy, ack, err
  );

  modport slave (
    input  address, datain, read, write, clear,
    output dataout, busy, ack, err
  );
endinterface

// File: rtl/ram_ctrl.sv
// Clocked data RAM controller: one read/write per transaction with a
// programmable number of wait states, a full-array clear sweep and
// out-of-range address flagging.
module ram_ctrl #(
  parameter int datalines   = 16,
  parameter int adlines     = 8,
  parameter int ramsize     = 256,
  parameter int wait_states = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  ram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, CLEAR} state_e;
  typedef logic [3:0]       wcnt_t;
  typedef logic [adlines:0] sweep_t;

  // WAIT holds for exactly wait_states cycles, so the counter is loaded with
  // one less; with zero wait states WAIT is skipped and ACCESS follows IDLE.
  localparam wcnt_t  WaitLoad  = wcnt_t'((wait_states > 0) ? wait_states - 1 : 0);
  localparam sweep_t RamSizeW  = sweep_t'(ramsize);
  localparam sweep_t SweepLast = sweep_t'(ramsize - 1);

  state_e                state_q, state_d;
  wcnt_t                 waitCnt_q, waitCnt_d;
  sweep_t                sweep_q, sweep_d;
  logic [adlines-1:0]    addr_q, addr_d;
  logic [datalines-1:0]  wdata_q, wdata_d;
  logic [datalines-1:0]  dout_q, dout_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  memWe;
  logic [adlines-1:0]    memWaddr;
  logic [datalines-1:0]  memWdata;
  logic                  inRange;

  logic [datalines-1:0]  mem [ramsize];

  assign inRange = ({1'b0, addr_q} < RamSizeW);

  // Next-state, capture and memory-port decode; requests are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    sweep_d   = sweep_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    dout_d    = dout_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    memWe     = 1'b0;
    memWaddr  = addr_q;
    memWdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = CLEAR;
          sweep_d = '0;
        end else if (bus.read || bus.write) begin
          addr_d    = bus.address;
          wdata_d   = bus.datain;
          rd_d      = bus.read;
          wr_d      = bus.write;
          waitCnt_d = WaitLoad;
          state_d   = (wait_states == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (waitCnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          waitCnt_d = waitCnt_q - wcnt_t'(1);
        end
      end
      ACCESS: begin
        memWe = wr_q && inRange;
        if (rd_q) begin
          if (!inRange) begin
            dout_d = '0;
          end else if (wr_q) begin
            dout_d = wdata_q;
          end else begin
            dout_d = mem[addr_q];
          end
        end
        ack_d   = 1'b1;
        err_d   = !inRange;
        state_d = IDLE;
      end
      CLEAR: begin
        memWe    = 1'b1;
        memWaddr = sweep_q[adlines-1:0];
        memWdata = '0;
        sweep_d  = sweep_q + sweep_t'(1);
        if (sweep_q == SweepLast) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
      sweep_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      dout_q    <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      sweep_q   <= sweep_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  // Storage array: synchronous write, no reset, so contents survive reset_n.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  assign bus.dataout = dout_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl. Two instances share the same request
// inputs: A (256 words, 2 wait states) and B (200 words, 0 wait states).
// A transaction-level model predicts every output of both after every edge.
module tb_ram_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  address;
  logic [15:0] datain;
  logic        read;
  logic        write;
  logic        clear;

  ram_ctrl_if #(.datalines(16), .adlines(8)) ifA ();
  ram_ctrl_if #(.datalines(16), .adlines(8)) ifB ();

  assign ifA.address = address;
  assign ifA.datain  = datain;
  assign ifA.read    = read;
  assign ifA.write   = write;
  assign ifA.clear   = clear;
  assign ifB.address = address;
  assign ifB.datain  = datain;
  assign ifB.read    = read;
  assign ifB.write   = write;
  assign ifB.clear   = clear;

  ram_ctrl #(.datalines(16), .adlines(8), .ramsize(256), .wait_states(2)) dutA (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifA)
  );

  ram_ctrl #(.datalines(16), .adlines(8), .ramsize(200), .wait_states(0)) dutB (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration as seen by the model.
  int waitCfg [2] = '{2, 0};
  int sizeCfg [2] = '{256, 200};

  // Reference model state.
  logic [15:0] mMem  [2][256];
  logic [15:0] mDout [2];
  bit          mAck  [2];
  bit          mErr  [2];
  bit          mPend [2];
  bit          mClr  [2];
  bit          mRd   [2];
  bit          mWr   [2];
  logic [7:0]  mAddr [2];
  logic [15:0] mData [2];
  int          mAcc  [2];
  int          mDone [2];
  int          edgeNo;

  // Observations gathered during one directed operation.
  int obsBusy   [2];
  int obsAck    [2];
  int obsErrAck [2];
  int obsAckOff [2];
  int accEdge;

  int cmpCnt;
  int failCnt;

  function automatic logic [15:0] doutOf(int d);
    return (d == 0) ? ifA.dataout : ifB.dataout;
  endfunction

  function automatic logic busyOf(int d);
    return (d == 0) ? ifA.busy : ifB.busy;
  endfunction

  function automatic logic ackOf(int d);
    return (d == 0) ? ifA.ack : ifB.ack;
  endfunction

  function automatic logic errOf(int d);
    return (d == 0) ? ifA.err : ifB.err;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mPend[d] = 1'b0;
      mAck[d]  = 1'b0;
      mErr[d]  = 1'b0;
      mDout[d] = '0;
    end
  endtask

  // What one rising edge does to instance d, from the transaction rules.
  task automatic modelEdge(input int d);
    bit inR;
    mAck[d] = 1'b0;
    mErr[d] = 1'b0;
    if (mPend[d]) begin
      if (mClr[d]) begin
        mMem[d][edgeNo - mAcc[d] - 1] = '0;
        if (edgeNo == mDone[d]) begin
          mAck[d]  = 1'b1;
          mPend[d] = 1'b0;
        end
      end else if (edgeNo == mDone[d]) begin
        inR = (int'(mAddr[d]) < sizeCfg[d]);
        if (mWr[d] && inR) mMem[d][mAddr[d]] = mData[d];
        if (mRd[d]) mDout[d] = inR ? mMem[d][mAddr[d]] : 16'h0000;
        mAck[d]  = 1'b1;
        mErr[d]  = !inR;
        mPend[d] = 1'b0;
      end
    end else if (clear || read || write) begin
      mPend[d] = 1'b1;
      mAcc[d]  = edgeNo;
      mClr[d]  = clear;
      mRd[d]   = read && !clear;
      mWr[d]   = write && !clear;
      mAddr[d] = address;
      mData[d] = datain;
      mDone[d] = clear ? edgeNo + sizeCfg[d] : edgeNo + 1 + waitCfg[d];
    end
  endtask

  task automatic checkAll();
    string nm;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "A" : "B";
      checkOutput({nm, ".busy"},    busyOf(d), mPend[d]);
      checkOutput({nm, ".ack"},     ackOf(d),  mAck[d]);
      checkOutput({nm, ".err"},     errOf(d),  mErr[d]);
      checkOutput({nm, ".dataout"}, doutOf(d), mDout[d]);
    end
  endtask

  // One clock: advance the model at the edge, compare 1 time unit later.
  task automatic tick();
    @(posedge clk);
    edgeNo++;
    if (reset_n) begin
      for (int d = 0; d < 2; d++) modelEdge(d);
    end
    #1;
    checkAll();
    for (int d = 0; d < 2; d++) begin
      obsBusy[d] += int'(busyOf(d));
      if (ackOf(d)) begin
        obsAck[d]++;
        if (errOf(d)) obsErrAck[d]++;
        if (obsAckOff[d] < 0) obsAckOff[d] = edgeNo - accEdge;
      end
    end
  endtask

  task automatic clrObs();
    for (int d = 0; d < 2; d++) begin
      obsBusy[d]   = 0;
      obsAck[d]    = 0;
      obsErrAck[d] = 0;
      obsAckOff[d] = -1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((mPend[0] || mPend[1]) && guard < 2000) begin
      tick();
      guard++;
    end
  endtask

  // Present one request for a single edge, then run until both instances finish.
  task automatic applyStimulus(input bit c, input bit r, input bit w,
                               input logic [7:0] a, input logic [15:0] dt);
    drain();
    clear   = c;
    read    = r;
    write   = w;
    address = a;
    datain  = dt;
    clrObs();
    accEdge = edgeNo + 1;
    tick();
    clear = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    drain();
  endtask

  initial begin
    cmpCnt  = 0;
    failCnt = 0;
    edgeNo  = 0;
    reset_n = 1'b0;
    address = '0;
    datain  = '0;
    read    = 1'b0;
    write   = 1'b0;
    clear   = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) mMem[d][i] = '0;
    modelReset();
    clrObs();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    reset_n = 1'b1;

    // Bring both arrays to a known state.
    $display("[TB] initial clear");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);

    // Write then read with wait states.
    $display("[TB] write/read 0x10");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h10, 16'hBEEF);
    checkOutput("wr10.A.busyCycles", obsBusy[0], 3);
    checkOutput("wr10.A.ackCount",   obsAck[0], 1);
    checkOutput("wr10.A.ackOffset",  obsAckOff[0], 3);
    checkOutput("wr10.B.ackOffset",  obsAckOff[1], 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    checkOutput("rd10.A.dataout",    ifA.dataout, 16'hBEEF);
    checkOutput("rd10.A.ackOffset",  obsAckOff[0], 3);
    checkOutput("rd10.B.dataout",    ifB.dataout, 16'hBEEF);

    // Simultaneous read and write.
    $display("[TB] write-then-read 0x05");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 16'h1234);
    checkOutput("wtr05.A.dataout",  ifA.dataout, 16'h1234);
    checkOutput("wtr05.A.ackCount", obsAck[0], 1);
    checkOutput("wtr05.B.dataout",  ifB.dataout, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    checkOutput("rd05.A.dataout",   ifA.dataout, 16'h1234);

    // Out of range only for B (200 words).
    $display("[TB] out-of-range 220");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd220, 16'hFFFF);
    checkOutput("wr220.B.errWithAck", obsErrAck[1], 1);
    checkOutput("wr220.A.errWithAck", obsErrAck[0], 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd220, 16'h0000);
    checkOutput("rd220.B.dataout",    ifB.dataout, 16'h0000);
    checkOutput("rd220.B.errWithAck", obsErrAck[1], 1);
    checkOutput("rd220.A.dataout",    ifA.dataout, 16'hFFFF);

    // Held read: back-to-back acceptance, mid-transaction write ignored.
    $display("[TB] held read 0x01");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 16'h0101);
    address = 8'h01;
    datain  = 16'hDEAD;
    read    = 1'b1;
    clrObs();
    accEdge = edgeNo + 1;
    tick();
    write = 1'b1;
    tick();
    write = 1'b0;
    repeat (6) tick();
    read = 1'b0;
    checkOutput("held.B.ackCount", obsAck[1], 4);
    checkOutput("held.A.ackCount", obsAck[0], 2);
    drain();
    checkOutput("held.B.dataout",  ifB.dataout, 16'h0101);
    checkOutput("held.A.dataout",  ifA.dataout, 16'h0101);

    // Reset while A is waiting on a write.
    $display("[TB] reset during wait");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 16'h5A5A);
    address = 8'h20;
    datain  = 16'h1111;
    write   = 1'b1;
    tick();
    write = 1'b0;
    tick();
    #3;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rstWait.A.busy",    ifA.busy, 1'b0);
    checkOutput("rstWait.A.ack",     ifA.ack, 1'b0);
    checkOutput("rstWait.A.dataout", ifA.dataout, 16'h0000);
    checkAll();
    #2;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    checkOutput("rd20.A.dataout", ifA.dataout, 16'h5A5A);
    checkOutput("rd20.B.dataout", ifB.dataout, 16'h1111);

    // Fill with random nonzero data, then sweep.
    $display("[TB] fill and clear");
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 16'($urandom_range(1, 65535)));
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd127, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    checkOutput("clr.A.busyCycles", obsBusy[0], 256);
    checkOutput("clr.A.ackOffset",  obsAckOff[0], 256);
    checkOutput("clr.A.ackCount",   obsAck[0], 1);
    checkOutput("clr.B.busyCycles", obsBusy[1], 200);
    checkOutput("clr.B.ackOffset",  obsAckOff[1], 200);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 16'h0000);
    checkOutput("clrRd0.A.dataout",   ifA.dataout, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd127, 16'h0000);
    checkOutput("clrRd127.A.dataout", ifA.dataout, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd255, 16'h0000);
    checkOutput("clrRd255.A.dataout", ifA.dataout, 16'h0000);

    // Free-running random requests, checked every cycle by the model.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      clear   = ($urandom_range(0, 249) == 0);
      read    = 1'($urandom_range(0, 1));
      write   = ($urandom_range(0, 2) == 0);
      address = 8'($urandom);
      datain  = 16'($urandom);
      tick();
    end
    clear = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    drain();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
    $finish;
  end

endmodule
